// File: rtl/button_conditioner.sv
// Button conditioner: turns one raw, bouncing, asynchronous push-button into a clean debounced
// level plus single-cycle press/release pulses, with optional hold-to-repeat press pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeating
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic             s1;
  logic             s2;
  logic [DB_W-1:0]  db_cnt;
  state_t           state;
  state_t           state_next;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_next;
  logic             press_next;
  logic             release_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (s2 == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt    <= '0;
      btn_level <= s2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  // The debounced level holds for at least DEBOUNCE_CYCLES, so a high level seen in IDLE
  // is always a fresh 0->1 transition.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE: begin
        if (btn_level) begin
          press_next = 1'b1;
          timer_next = '0;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!btn_level) begin
          release_next = 1'b1;
          state_next   = IDLE;
        end else if (REPEAT_EN) begin
          if (timer == DELAY_LAST) begin
            press_next = 1'b1;
            timer_next = '0;
            state_next = REPEAT;
          end else begin
            timer_next = timer + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!btn_level) begin
          release_next = 1'b1;
          state_next   = IDLE;
        end else if (timer == PERIOD_LAST) begin
          press_next = 1'b1;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign repeating = (state == REPEAT);

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized scoreboard bench for button_conditioner: two instances (repeat on/off) share stimulus;
// an event-level reference model predicts level, repeating and pulse edges.
module tb_button_conditioner;

  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic lvl_a, press_a, rel_a, rep_a;
  logic lvl_b, press_b, rel_b, rep_b;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) u_rep (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(lvl_a), .press_pulse(press_a), .release_pulse(rel_a), .repeating(rep_a)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) u_norep (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(lvl_b), .press_pulse(press_b), .release_pulse(rel_b), .repeating(rep_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected pulse edges: 0 press_a, 1 release_a, 2 press_b, 3 release_b
  int exp_q[4][$];

  int m_edge    = 0;
  bit m_lvl     = 1'b0;
  int m_run     = 0;
  bit hist[$];
  int rise_edge = -1000;
  int fall_edge = -1000;
  bit exp_lvl   = 1'b0;
  bit exp_rep_a = 1'b0;

  task automatic checkOutput(input string name, input int edge_n,
                             input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at edge %0d: got %0d want %0d", name, edge_n, actual, expected);
    end
  endtask

  // Reference model: debounced level from run lengths of the 2-edge-delayed input,
  // pulses scheduled arithmetically from the rise/fall edges of that level.
  task automatic modelStep(input bit b, input bit r);
    bit lvl_before;
    bit sync;
    int n;
    n = m_edge;
    if (r) begin
      m_lvl     = 1'b0;
      m_run     = 0;
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
      rise_edge = -1000;
      fall_edge = -1000;
      exp_lvl   = 1'b0;
      exp_rep_a = 1'b0;
    end else begin
      lvl_before = m_lvl;
      if (lvl_before && n == rise_edge + 1) begin
        exp_q[0].push_back(n);
        exp_q[2].push_back(n);
      end
      if (lvl_before && n >= rise_edge + 1 + DLY && ((n - rise_edge - 1 - DLY) % PER) == 0)
        exp_q[0].push_back(n);
      if (!lvl_before && n == fall_edge + 1) begin
        exp_q[1].push_back(n);
        exp_q[3].push_back(n);
      end
      exp_rep_a = lvl_before && (n >= rise_edge + 1 + DLY);
      sync = hist.pop_front();
      hist.push_back(b);
      if (sync != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = sync;
          m_run = 0;
          if (sync) rise_edge = n;
          else      fall_edge = n;
        end
      end else begin
        m_run = 0;
      end
      exp_lvl = m_lvl;
    end
    m_edge++;
  endtask

  task automatic applyStimulus(input bit b, input bit r);
    btn_in = b;
    rst    = r;
    modelStep(b, r);
    @(negedge clk);
  endtask

  // Monitor: one step after each rising edge, compare every output with the scoreboard.
  always @(posedge clk) begin
    int e;
    logic [3:0] pulses;
    string names[4];
    #1;
    e = m_edge - 1;
    pulses = {rel_b, press_b, rel_a, press_a};
    names = '{"press_rep", "release_rep", "press_norep", "release_norep"};
    for (int s = 0; s < 4; s++) begin
      if (exp_q[s].size() > 0 && exp_q[s][0] == e) begin
        void'(exp_q[s].pop_front());
        checkOutput(names[s], e, {31'd0, pulses[s]}, 32'd1);
      end else begin
        checkOutput(names[s], e, {31'd0, pulses[s]}, 32'd0);
      end
    end
    checkOutput("level_rep", e, {31'd0, lvl_a}, {31'd0, exp_lvl});
    checkOutput("level_norep", e, {31'd0, lvl_b}, {31'd0, exp_lvl});
    checkOutput("repeating_rep", e, {31'd0, rep_a}, {31'd0, exp_rep_a});
    checkOutput("repeating_norep", e, {31'd0, rep_b}, 32'd0);
  end

  initial begin
    bit b;
    bit r;
    int len;
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b1);

    // Short glitch that must be rejected
    repeat (3)  applyStimulus(1'b1, 1'b0);
    repeat (12) applyStimulus(1'b0, 1'b0);

    // Long hold into auto-repeat, then a bouncy release
    repeat (40) applyStimulus(1'b1, 1'b0);
    repeat (3)  applyStimulus(1'b0, 1'b0);
    repeat (2)  applyStimulus(1'b1, 1'b0);
    repeat (3)  applyStimulus(1'b0, 1'b0);
    repeat (2)  applyStimulus(1'b1, 1'b0);
    repeat (15) applyStimulus(1'b0, 1'b0);

    // Reset pulse while held in HOLD
    repeat (12) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    repeat (30) applyStimulus(1'b1, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b0);

    // Very long hold
    repeat (100) applyStimulus(1'b1, 1'b0);
    repeat (20)  applyStimulus(1'b0, 1'b0);

    // Random segments with occasional reset
    for (int seg = 0; seg < 150; seg++) begin
      b   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 25));
      r   = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < len; i++) applyStimulus(b, r && (i == 0));
    end
    repeat (20) applyStimulus(1'b0, 1'b0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
